// File: rtl/instruction_memory_pipelined_pkg.sv
// Shared definitions for the pipelined instruction memory.
//   imem_state_t : control states (FETCH after reset, LOAD during a program burst)
//   fault_t      : fault code returned with every fetched word
//   DEF_*        : default parameter values for the top level
package instruction_memory_pipelined_pkg;

  typedef enum logic {
    FETCH = 1'b0,
    LOAD  = 1'b1
  } imem_state_t;

  typedef enum logic [1:0] {
    OK           = 2'b00,
    MISALIGNED   = 2'b01,
    OUT_OF_RANGE = 2'b10
  } fault_t;

  localparam int DEF_WORD_W = 32;
  localparam int DEF_DEPTH  = 256;
  localparam int DEF_ADDR_W = 32;

endpackage

// File: rtl/instruction_memory_pipelined_imem_array.sv
// Storage array for the instruction memory.
// One synchronous write port and one synchronous read port; the read data
// register only updates when i_rd_en is high, so it holds its value otherwise.
// Contents are never reset or initialised.
//   i_clk     : clock
//   i_wr_en   : write strobe
//   i_wr_addr : write word index
//   i_wr_data : write data
//   i_rd_en   : read strobe
//   i_rd_addr : read word index
//   o_rd_data : registered read data
module imem_array #(
  parameter int WORD_W = 32,
  parameter int DEPTH  = 256
) (
  input  logic                     i_clk,
  input  logic                     i_wr_en,
  input  logic [$clog2(DEPTH)-1:0] i_wr_addr,
  input  logic [WORD_W-1:0]        i_wr_data,
  input  logic                     i_rd_en,
  input  logic [$clog2(DEPTH)-1:0] i_rd_addr,
  output logic [WORD_W-1:0]        o_rd_data
);

  logic [WORD_W-1:0] r_mem [DEPTH];
  logic [WORD_W-1:0] r_rd_data;

  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rd_en) begin
      r_rd_data <= r_mem[i_rd_addr];
    end
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/instruction_memory_pipelined.sv
// Pipelined instruction memory with a program-load port.
// FETCH: byte-addressed fetches with one-cycle latency and valid/ready
//        back-pressure on the result. LOAD: a burst of load_count words is
//        written from index 0 upwards, one per cycle with load_valid high.
//   clock, reset_n      : clock, asynchronous active-low reset
//   fetch_req/ready/addr: fetch request handshake and byte address
//   instr_valid/ready   : result handshake
//   instr_word/addr/fault: fetched word, its byte address, fault code
//   load_start/count    : start a burst of load_count words
//   load_valid/data     : burst data
//   load_busy, load_done: LOAD state active, end-of-burst pulse
module instruction_memory_pipelined
  import instruction_memory_pipelined_pkg::*;
#(
  parameter int WORD_W = DEF_WORD_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       fetch_req,
  output logic                       fetch_ready,
  input  logic [ADDR_W-1:0]          fetch_addr,
  output logic                       instr_valid,
  input  logic                       instr_ready,
  output logic [WORD_W-1:0]          instr_word,
  output logic [ADDR_W-1:0]          instr_addr,
  output logic [1:0]                 instr_fault,
  input  logic                       load_start,
  input  logic [$clog2(DEPTH):0]     load_count,
  input  logic                       load_valid,
  input  logic [WORD_W-1:0]          load_data,
  output logic                       load_busy,
  output logic                       load_done
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  // Control FSM and load burst
  imem_state_t   r_state;
  imem_state_t   w_state_nxt;
  logic [CW-1:0] r_count;
  logic [CW-1:0] r_wptr;
  logic [CW-1:0] w_count_clamped;
  logic          r_load_done;
  logic          w_load_done_nxt;
  logic          w_load_go;
  logic          w_wr_en;

  assign w_count_clamped = (load_count > CW'(DEPTH)) ? CW'(DEPTH) : load_count;

  always_comb begin
    w_state_nxt     = r_state;
    w_load_done_nxt = 1'b0;
    w_load_go       = 1'b0;
    w_wr_en         = 1'b0;
    case (r_state)
      FETCH: begin
        if (load_start) begin
          // An empty burst completes immediately without visiting LOAD.
          if (w_count_clamped == '0) begin
            w_load_done_nxt = 1'b1;
          end else begin
            w_state_nxt = LOAD;
            w_load_go   = 1'b1;
          end
        end
      end
      LOAD: begin
        if (load_valid) begin
          w_wr_en = 1'b1;
          if (r_wptr == r_count - CW'(1)) begin
            w_state_nxt     = FETCH;
            w_load_done_nxt = 1'b1;
          end
        end
      end
      default: w_state_nxt = FETCH;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= FETCH;
      r_count     <= '0;
      r_wptr      <= '0;
      r_load_done <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_load_done <= w_load_done_nxt;
      if (w_load_go) begin
        r_count <= w_count_clamped;
        r_wptr  <= '0;
      end else if (w_wr_en) begin
        r_wptr  <= r_wptr + CW'(1);
      end
    end
  end

  assign load_busy = (r_state == LOAD);
  assign load_done = r_load_done;

  // Fetch request decode
  logic          w_fetch_ready;
  logic          w_accept;
  logic          w_misaligned;
  logic          w_out_of_range;
  fault_t        w_fault;
  logic          w_rd_en;
  logic [WORD_W-1:0] w_rd_data;

  assign w_fetch_ready  = (r_state == FETCH) && (!instr_valid || instr_ready);
  assign w_accept       = fetch_req && w_fetch_ready;
  assign w_misaligned   = |fetch_addr[1:0];
  // DEPTH is a power of two, so index >= DEPTH means any bit above the index is set.
  assign w_out_of_range = |fetch_addr[ADDR_W-1:AW+2];
  assign w_fault        = w_misaligned   ? MISALIGNED :
                          w_out_of_range ? OUT_OF_RANGE : OK;
  assign w_rd_en        = w_accept && (w_fault == OK);
  assign fetch_ready    = w_fetch_ready;

  imem_array #(
    .WORD_W (WORD_W),
    .DEPTH  (DEPTH)
  ) u_imem_array (
    .i_clk     (clock),
    .i_wr_en   (w_wr_en),
    .i_wr_addr (r_wptr[AW-1:0]),
    .i_wr_data (load_data),
    .i_rd_en   (w_rd_en),
    .i_rd_addr (fetch_addr[AW+1:2]),
    .o_rd_data (w_rd_data)
  );

  // Result register: the array read data is only qualified by r_word_ok,
  // which zeroes the word after reset and for faulted fetches.
  logic              r_valid;
  logic [ADDR_W-1:0] r_addr;
  fault_t            r_fault;
  logic              r_word_ok;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_valid   <= 1'b0;
      r_addr    <= '0;
      r_fault   <= OK;
      r_word_ok <= 1'b0;
    end else if (w_accept) begin
      r_valid   <= 1'b1;
      r_addr    <= fetch_addr;
      r_fault   <= w_fault;
      r_word_ok <= (w_fault == OK);
    end else if (instr_ready) begin
      r_valid   <= 1'b0;
    end
  end

  assign instr_valid = r_valid;
  assign instr_addr  = r_addr;
  assign instr_fault = r_fault;
  assign instr_word  = r_word_ok ? w_rd_data : '0;

endmodule

// File: tb/tb_instruction_memory_pipelined.sv
// Directed self-checking bench for instruction_memory_pipelined.
module tb_instruction_memory_pipelined;

  localparam int WORD_W = 32;
  localparam int DEPTH  = 256;
  localparam int ADDR_W = 32;
  localparam int CW     = 9;

  logic              clock = 1'b0;
  logic              reset_n;
  logic              fetch_req;
  logic              fetch_ready;
  logic [ADDR_W-1:0] fetch_addr;
  logic              instr_valid;
  logic              instr_ready;
  logic [WORD_W-1:0] instr_word;
  logic [ADDR_W-1:0] instr_addr;
  logic [1:0]        instr_fault;
  logic              load_start;
  logic [CW-1:0]     load_count;
  logic              load_valid;
  logic [WORD_W-1:0] load_data;
  logic              load_busy;
  logic              load_done;

  instruction_memory_pipelined #(
    .WORD_W (WORD_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .fetch_req   (fetch_req),
    .fetch_ready (fetch_ready),
    .fetch_addr  (fetch_addr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr_word  (instr_word),
    .instr_addr  (instr_addr),
    .instr_fault (instr_fault),
    .load_start  (load_start),
    .load_count  (load_count),
    .load_valid  (load_valid),
    .load_data   (load_data),
    .load_busy   (load_busy),
    .load_done   (load_done)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // One fetch, consumed immediately.
  task automatic fetch_one(input string tag, input logic [31:0] addr,
                           input bit chk_word, input logic [31:0] word,
                           input logic [1:0] fault);
    fetch_req   = 1'b1;
    fetch_addr  = addr;
    instr_ready = 1'b1;
    #1;
    check_eq({tag, "_ready"}, fetch_ready, 1'b1);
    step();
    fetch_req = 1'b0;
    check_eq({tag, "_valid"}, instr_valid, 1'b1);
    check_eq({tag, "_addr"}, instr_addr, addr);
    check_eq({tag, "_fault"}, instr_fault, fault);
    if (chk_word) check_eq({tag, "_word"}, instr_word, word);
    step();
    check_eq({tag, "_drop"}, instr_valid, 1'b0);
  endtask

  // Burst stimulus: one entry per cycle after the load_start cycle.
  bit          q_vld   [$];
  logic [31:0] q_data  [$];
  bit          q_start [$];

  task automatic run_load(input string tag, input logic [CW-1:0] cnt,
                          input int exp_busy, input bit chk_hold,
                          input logic [31:0] hold_word);
    int busy_n;
    int done_n;
    int hold_bad;
    busy_n = 0; done_n = 0; hold_bad = 0;
    load_start = 1'b1;
    load_count = cnt;
    step();
    load_start = 1'b0;
    busy_n += int'(load_busy);
    done_n += int'(load_done);
    if (chk_hold && (instr_valid !== 1'b1 || instr_word !== hold_word)) hold_bad++;
    for (int i = 0; i < q_vld.size(); i++) begin
      load_valid = q_vld[i];
      load_data  = q_data[i];
      load_start = q_start[i];
      load_count = 9'd1;
      step();
      busy_n += int'(load_busy);
      done_n += int'(load_done);
      if (chk_hold && (instr_valid !== 1'b1 || instr_word !== hold_word)) hold_bad++;
    end
    load_valid = 1'b0;
    load_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      busy_n += int'(load_busy);
      done_n += int'(load_done);
    end
    check_eq({tag, "_busy_cycles"}, busy_n, exp_busy);
    check_eq({tag, "_done_pulses"}, done_n, 1);
    if (chk_hold) check_eq({tag, "_hold"}, hold_bad, 0);
    q_vld.delete(); q_data.delete(); q_start.delete();
  endtask

  initial begin
    int done_n;
    reset_n = 1'b0; fetch_req = 1'b0; fetch_addr = '0; instr_ready = 1'b0;
    load_start = 1'b0; load_count = '0; load_valid = 1'b0; load_data = '0;
    repeat (3) step();
    check_eq("rst_valid", instr_valid, 1'b0);
    check_eq("rst_word", instr_word, 32'h0);
    check_eq("rst_addr", instr_addr, 32'h0);
    check_eq("rst_fault", instr_fault, 2'b00);
    check_eq("rst_busy", load_busy, 1'b0);
    check_eq("rst_done", load_done, 1'b0);
    reset_n = 1'b1;
    #1;
    check_eq("rst_fetch_ready", fetch_ready, 1'b1);

    // Load A, B, C
    q_vld = '{1, 1, 1}; q_data = '{32'hA, 32'hB, 32'hC}; q_start = '{0, 0, 0};
    run_load("load3", 9'd3, 3, 1'b0, 32'h0);
    fetch_one("f0", 32'h0, 1'b1, 32'hA, 2'b00);
    fetch_one("f4", 32'h4, 1'b1, 32'hB, 2'b00);
    fetch_one("f8", 32'h8, 1'b1, 32'hC, 2'b00);

    // Back-to-back fetches
    instr_ready = 1'b1;
    fetch_req = 1'b1; fetch_addr = 32'h0;
    step();
    check_eq("b2b0_word", instr_word, 32'hA);
    check_eq("b2b0_addr", instr_addr, 32'h0);
    fetch_addr = 32'h4;
    step();
    check_eq("b2b1_valid", instr_valid, 1'b1);
    check_eq("b2b1_word", instr_word, 32'hB);
    check_eq("b2b1_addr", instr_addr, 32'h4);
    fetch_addr = 32'h8;
    step();
    check_eq("b2b2_valid", instr_valid, 1'b1);
    check_eq("b2b2_word", instr_word, 32'hC);
    check_eq("b2b2_addr", instr_addr, 32'h8);
    fetch_req = 1'b0;
    step();
    check_eq("b2b_drop", instr_valid, 1'b0);

    // Stall
    fetch_req = 1'b1; fetch_addr = 32'h4; instr_ready = 1'b1;
    step();
    instr_ready = 1'b0; fetch_addr = 32'h8;
    for (int i = 0; i < 4; i++) begin
      #1;
      check_eq("stall_ready", fetch_ready, 1'b0);
      check_eq("stall_valid", instr_valid, 1'b1);
      check_eq("stall_word", instr_word, 32'hB);
      check_eq("stall_addr", instr_addr, 32'h4);
      step();
    end
    instr_ready = 1'b1;
    #1;
    check_eq("release_ready", fetch_ready, 1'b1);
    step();
    fetch_req = 1'b0;
    check_eq("release_word", instr_word, 32'hC);
    check_eq("release_addr", instr_addr, 32'h8);
    step();
    check_eq("release_drop", instr_valid, 1'b0);

    // Faults
    fetch_one("flt_2", 32'h2, 1'b1, 32'h0, 2'b01);
    fetch_one("flt_400", 32'h400, 1'b1, 32'h0, 2'b10);
    fetch_one("flt_402", 32'h402, 1'b1, 32'h0, 2'b01);
    fetch_one("edge_3fc", 32'h3FC, 1'b0, 32'h0, 2'b00);

    // Reset during a burst of 4 after two writes
    load_start = 1'b1; load_count = 9'd4;
    step();
    load_start = 1'b0; load_valid = 1'b1; load_data = 32'h11;
    step();
    load_data = 32'h22;
    step();
    load_valid = 1'b0;
    check_eq("mid_busy_before", load_busy, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    check_eq("mid_busy_async", load_busy, 1'b0);
    check_eq("mid_done_async", load_done, 1'b0);
    step();
    reset_n = 1'b1;
    done_n = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      done_n += int'(load_done);
    end
    check_eq("mid_no_done", done_n, 0);
    check_eq("mid_busy_after", load_busy, 1'b0);
    fetch_one("mid_w0", 32'h0, 1'b1, 32'h11, 2'b00);
    fetch_one("mid_w1", 32'h4, 1'b1, 32'h22, 2'b00);
    fetch_one("mid_w2", 32'h8, 1'b1, 32'hC, 2'b00);

    // Output held through LOAD; gapped burst with an ignored load_start
    fetch_req = 1'b1; fetch_addr = 32'h8; instr_ready = 1'b0;
    step();
    fetch_req = 1'b0;
    q_vld   = '{1, 0, 1, 0, 1};
    q_data  = '{32'h100, 32'hDEAD, 32'h200, 32'hBEEF, 32'h300};
    q_start = '{0, 1, 0, 1, 0};
    run_load("gaps", 9'd3, 5, 1'b1, 32'hC);
    check_eq("held_valid", instr_valid, 1'b1);
    check_eq("held_word", instr_word, 32'hC);
    instr_ready = 1'b1;
    step();
    check_eq("held_drop", instr_valid, 1'b0);
    fetch_one("gaps_w0", 32'h0, 1'b1, 32'h100, 2'b00);
    fetch_one("gaps_w1", 32'h4, 1'b1, 32'h200, 2'b00);
    fetch_one("gaps_w2", 32'h8, 1'b1, 32'h300, 2'b00);

    // Empty burst
    run_load("cnt0", 9'd0, 0, 1'b0, 32'h0);
    fetch_one("cnt0_w0", 32'h0, 1'b1, 32'h100, 2'b00);

    // Count above DEPTH clamps to DEPTH
    for (int i = 0; i < DEPTH; i++) begin
      q_vld.push_back(1'b1);
      q_data.push_back(32'h1000 + i);
      q_start.push_back(1'b0);
    end
    run_load("clamp", 9'd300, DEPTH, 1'b0, 32'h0);
    fetch_one("clamp_w0", 32'h0, 1'b1, 32'h1000, 2'b00);
    fetch_one("clamp_w255", 32'h3FC, 1'b1, 32'h10FF, 2'b00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instruction_memory_pipelined.md
INSTRUCTION_MEMORY_PIPELINED -- requirements
Module: instruction_memory_pipelined

Interface
REQ-001 Parameter WORD_W, default 32: instruction word width in bits.
REQ-002 Parameter DEPTH, default 256: number of words stored; power of two, at least 4.
REQ-003 Parameter ADDR_W, default 32: width of the byte address bus.
REQ-004 The port list SHALL be as follows, one port per line, in this order:
- clock  in  1  single clock; all state updates on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- fetch_req  in  1  fetch request valid.
- fetch_ready  out  1  fetch request accepted this cycle.
- fetch_addr  in  ADDR_W  byte address of the requested instruction.
- instr_valid  out  1  instr_word, instr_addr and instr_fault are valid.
- instr_ready  in  1  consumer accepts the output.
- instr_word  out  WORD_W  fetched instruction, bit WORD_W-1 is the MSB.
- instr_addr  out  ADDR_W  byte address that produced instr_word.
- instr_fault  out  2  00 ok, 01 misaligned, 10 out of range.
- load_start  in  1  begin a program-load burst.
- load_count  in  $clog2(DEPTH)+1  number of words in the burst.
- load_valid  in  1  load_data is valid.
- load_data  in  WORD_W  next word to write.
- load_busy  out  1  high while the LOAD state is active.
- load_done  out  1  one-cycle pulse after the last word of a burst is written.

Function
REQ-005 The block SHALL have two states: FETCH, the state entered from reset, and LOAD.
REQ-006 In FETCH, a high load_start SHALL move the block to LOAD on the next edge and latch load_count. A load_count of 0 SHALL instead produce a load_done pulse and keep the block in FETCH.
REQ-007 Entering LOAD SHALL clear the write pointer to 0.
REQ-008 Each cycle in LOAD with load_valid high SHALL write load_data to mem[write pointer] and then increment the write pointer.
REQ-009 After writing word load_count-1, the block SHALL return to FETCH and pulse load_done in the next cycle.
REQ-010 load_start SHALL be ignored while the block is in LOAD.
REQ-011 load_count values greater than DEPTH SHALL be clamped to DEPTH.
REQ-012 fetch_ready SHALL be 0 while in LOAD; in FETCH it SHALL equal (!instr_valid || instr_ready).
REQ-013 A fetch SHALL be accepted in any cycle where fetch_req and fetch_ready are both high.
REQ-014 An accepted fetch SHALL present its result at the next edge, a latency of one cycle, with instr_valid set to 1 and instr_addr equal to fetch_addr.
REQ-015 The word index SHALL be fetch_addr[ADDR_W-1:2]; fetch_addr[1:0] SHALL be dropped.
REQ-016 An accepted fetch with fetch_addr[1:0] != 0 SHALL return instr_fault=01 and instr_word=0.
REQ-017 An accepted fetch with word index >= DEPTH SHALL return instr_fault=10 and instr_word=0.
REQ-018 If both fault conditions hold, misaligned (01) SHALL take priority.
REQ-019 While instr_valid is 1 and instr_ready is 0, instr_word, instr_addr and instr_fault SHALL be held stable.
REQ-020 When an output is consumed in the same cycle a new fetch is accepted, the block SHALL present the new result on the next edge with no bubble.
REQ-021 When an output is consumed and no new fetch is accepted, instr_valid SHALL drop to 0 on the next edge.
REQ-022 An output registered before load_start SHALL remain valid through LOAD until it is consumed.
REQ-023 Memory contents SHALL be left uninitialised; bit-for-bit contents before any load are unspecified.

Reset
REQ-024 Asserting reset_n low SHALL asynchronously force the following values: state FETCH, write pointer 0, instr_valid 0, instr_word 0, instr_addr 0, instr_fault 00, load_busy 0, load_done 0.
REQ-025 Memory contents SHALL NOT be cleared by reset.
REQ-026 A reset asserted mid-LOAD SHALL abort the burst: words already written are retained and no load_done pulse is produced.
REQ-027 After reset is released, fetch_ready SHALL be 1 in the first cycle.

Structure
REQ-028 A shared package SHALL hold the state enum (FETCH, LOAD), the fault codes (OK=00, MISALIGNED=01, OUT_OF_RANGE=10) and the default parameter values.
REQ-029 The storage array SHALL be a sub-module named imem_array, with one synchronous write port and one synchronous read port, parametrised by WORD_W and DEPTH.

Verification
REQ-030 Load burst: load_count=3 with data 0xA, 0xB, 0xC and load_valid held high -> load_busy for 3 cycles, load_done pulses once; then fetches of 0x0, 0x4, 0x8 return 0xA, 0xB, 0xC, each one cycle after acceptance, with fault 00.
REQ-031 Back-to-back fetches with instr_ready held high -> one result per cycle, no bubbles, instr_addr tracks each request.
REQ-032 Stall: instr_ready=0 for 4 cycles with fetch_req held high -> fetch_ready=0 and outputs stable throughout; on release the next fetch completes one cycle later.
REQ-033 Faults: fetch 0x2 -> fault 01 and word 0; fetch 0x400 with DEPTH=256 -> fault 10; fetch 0x402 -> fault 01.
REQ-034 Reset mid-load: load_count=4, reset_n pulsed low after 2 writes -> state FETCH, no load_done; words 0 and 1 hold the loaded values.
REQ-035 Gaps and counts: load_valid toggling in LOAD -> only valid cycles write; load_start in LOAD is ignored; load_count=0 -> immediate load_done with no write.
